instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 37 +++
 rtl/instruction_fetch.sv | 154 +++++++++++++++
 tb/tb_instruction_fetch.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: instruction memory port, branch redirect and decode handshake.
// The fetch unit is the master; memory, branch logic and decode sit on the slave side.
interface instruction_fetch_if;
    logic [31:0] fetch_address;
    logic [31:0] fetch_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    modport master (
        output fetch_address,
        input  fetch_data,
        input  branch_taken,
        input  branch_target,
        input  inst_ready,
        output inst_valid,
        output inst_out,
        output inst_pc,
        output fetch_fault
    );

    modport slave (
        input  fetch_address,
        output fetch_data,
        output branch_taken,
        output branch_target,
        output inst_ready,
        input  inst_valid,
        input  inst_out,
        input  inst_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: sequential PC generation, one read in flight to a
// synchronous instruction memory, and a 2-entry {instruction, pc} queue towards decode.
// Branch redirects flush the queue and drop the in-flight read.
// Optional build macro FETCH_FAULT_CHECK_EN: misaligned or out-of-range fetch
// addresses raise a sticky fetch_fault and halt fetching until reset. Without it,
// branch targets are word-aligned by dropping bits [1:0] and the PC wraps at MEM_BYTES.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic                clk,
    input  logic                resetn,
    instruction_fetch_if.master fbus
);
    localparam int unsigned     XLEN    = 32;
    localparam int unsigned     CNT_W   = 2;
    localparam int unsigned     OCC_W   = CNT_W + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fifo_entry_t;

    // Architectural state
    logic [XLEN-1:0]  pc_q,     pc_d;
    logic             req_q,    req_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    fifo_entry_t      head_q,   head_d;
    fifo_entry_t      tail_q,   tail_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             valid_q,  valid_d;
    logic             fault_q,  fault_d;

    // Per-cycle decisions
    logic             pop_c;
    logic             redirect_c;
    logic             push_c;
    logic             issue_c;
    logic             fault_set_c;
    logic [OCC_W-1:0] occ_c;
    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  seq_pc_c;
    fifo_entry_t      new_entry_c;

    // Outputs come straight from registers
    assign fbus.fetch_address = pc_q;
    assign fbus.inst_valid    = valid_q;
    assign fbus.inst_out      = head_q.inst;
    assign fbus.inst_pc       = head_q.pc;
`ifdef FETCH_FAULT_CHECK_EN
    assign fbus.fetch_fault   = fault_q;
`else
    assign fbus.fetch_fault   = 1'b0;
`endif

    // Next-state: redirect/fault flush, queue push/pop, and issue of the next read
    always_comb begin
        pc_d     = pc_q;
        req_d    = 1'b0;
        req_pc_d = req_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        fault_d  = fault_q;

        pop_c      = valid_q && fbus.inst_ready;
        redirect_c = fbus.branch_taken && !fault_q;
        push_c     = req_q && !redirect_c;
        // Occupancy the queue would reach if the read issued now lands
        occ_c      = OCC_W'(count_q) + OCC_W'(req_q) - OCC_W'(pop_c);
        issue_c    = !fault_q && !redirect_c && (occ_c <= OCC_W'(1));

`ifdef FETCH_FAULT_CHECK_EN
        target_c    = fbus.branch_target;
        seq_pc_c    = pc_q + PC_STEP;
        fault_set_c = (redirect_c && ((target_c[1:0] != 2'b00) || (target_c > LAST_PC)))
                   || (issue_c && (pc_q > LAST_PC));
`else
        target_c    = fbus.branch_target & ~XLEN'(3);
        seq_pc_c    = (pc_q >= LAST_PC) ? '0 : (pc_q + PC_STEP);
        fault_set_c = 1'b0;
`endif

        new_entry_c = '{inst: fbus.fetch_data, pc: req_pc_q};

        if (fault_set_c) begin
            // Park on the offending address with nothing queued or in flight
            fault_d = 1'b1;
            count_d = '0;
            pc_d    = redirect_c ? target_c : pc_q;
        end else if (redirect_c) begin
            count_d = '0;
            pc_d    = target_c;
        end else begin
            unique case ({push_c, pop_c})
                2'b10: begin
                    if (count_q == '0) begin
                        head_d = new_entry_c;
                    end else begin
                        tail_d = new_entry_c;
                    end
                    count_d = count_q + CNT_W'(1);
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - CNT_W'(1);
                end
                2'b11: begin
                    if (count_q == CNT_W'(1)) begin
                        head_d = new_entry_c;
                    end else begin
                        head_d = tail_q;
                        tail_d = new_entry_c;
                    end
                end
                default: begin
                end
            endcase

            if (issue_c) begin
                req_d    = 1'b1;
                req_pc_d = pc_q;
                pc_d     = seq_pc_c;
            end
        end

        valid_d = (count_d != '0);
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            req_q    <= req_d;
            req_pc_q <= req_pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed latency/backpressure/redirect/reset
// scenarios plus a randomized stream checked against an in-order address model.
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_BYTES = 2048;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    logic [31:0] mem [512];

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .fbus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data for an address appears one edge later
    always @(posedge clk) begin
        bus.fetch_data <= mem[bus.fetch_address[10:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.inst_ready    = 1'b0;
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        checks++; if (bus.fetch_address !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", bus.fetch_address, RESET_PC); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
        checks++; if (bus.inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus.inst_out); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.inst_pc); end
        checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bus.fetch_fault); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        bus.inst_ready = 1'b1;
        step();
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: valid got %b expected 0", bus.inst_valid); end
        for (int i = 0; i < 3; i++) begin
            step();
            exp = RESET_PC + 32'(i * 4);
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp || bus.inst_out !== mem[exp[10:2]]) begin
                errors++; $display("FAIL stream_seq%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", i, bus.inst_valid, bus.inst_pc, bus.inst_out, exp, mem[exp[10:2]]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_reset();
        bus.inst_ready = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c >= 3) begin
                checks++; if (bus.fetch_address !== 32'h8 || bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0) begin
                    errors++; $display("FAIL bp_freeze%0d: got addr=%h v=%b pc=%h expected addr=8 v=1 pc=0", c, bus.fetch_address, bus.inst_valid, bus.inst_pc);
                end
            end
        end
        bus.inst_ready = 1'b1;
        exp = 32'h0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp || bus.inst_out !== mem[exp[10:2]]) begin
                errors++; $display("FAIL bp_resume%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", i, bus.inst_valid, bus.inst_pc, bus.inst_out, exp, mem[exp[10:2]]);
            end
            exp = exp + 32'h4;
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.inst_ready = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.inst_pc !== 32'h4) begin errors++; $display("FAIL redir_pre: pc got %h expected 4", bus.inst_pc); end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        step();
        bus.branch_taken = 1'b0;
        checks++; if (bus.fetch_address !== 32'h40 || bus.inst_valid !== 1'b0) begin
            errors++; $display("FAIL redir_addr: got addr=%h v=%b expected addr=40 v=0", bus.fetch_address, bus.inst_valid);
        end
        step();
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL redir_gap: valid got %b expected 0", bus.inst_valid); end
        step();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40 || bus.inst_out !== mem[16]) begin
            errors++; $display("FAIL redir_first: got v=%b pc=%h inst=%h expected v=1 pc=40 inst=%h", bus.inst_valid, bus.inst_pc, bus.inst_out, mem[16]);
        end
        step();
        checks++; if (bus.inst_pc !== 32'h44) begin errors++; $display("FAIL redir_next: pc got %h expected 44", bus.inst_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.inst_ready = 1'b1;
        step();
        step();
        step();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h100;
        step();
        checks++; if (bus.fetch_address !== 32'h100) begin errors++; $display("FAIL b2b_first: addr got %h expected 100", bus.fetch_address); end
        bus.branch_target = 32'h200;
        step();
        bus.branch_taken = 1'b0;
        checks++; if (bus.fetch_address !== 32'h200 || bus.inst_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got addr=%h v=%b expected addr=200 v=0", bus.fetch_address, bus.inst_valid);
        end
        step();
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: valid got %b expected 0", bus.inst_valid); end
        step();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h200) begin
            errors++; $display("FAIL b2b_deliver: got v=%b pc=%h expected v=1 pc=200", bus.inst_valid, bus.inst_pc);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.inst_ready = 1'b0;
        for (int c = 0; c < 4; c++) step();
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL mid_pre: valid got %b expected 1", bus.inst_valid); end
        resetn = 1'b0;
        #1;
        checks++; if (bus.inst_valid !== 1'b0 || bus.fetch_address !== RESET_PC || bus.inst_pc !== 32'h0) begin
            errors++; $display("FAIL mid_async: got v=%b addr=%h pc=%h expected v=0 addr=%h pc=0", bus.inst_valid, bus.fetch_address, bus.inst_pc, RESET_PC);
        end
        step();
        resetn = 1'b1;
        bus.inst_ready = 1'b1;
        step();
        checks++; if (bus.inst_valid !== 1'b0 || bus.fetch_address !== RESET_PC + 32'h4) begin
            errors++; $display("FAIL mid_restart: got v=%b addr=%h expected v=0 addr=%h", bus.inst_valid, bus.fetch_address, RESET_PC + 32'h4);
        end
        step();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== RESET_PC) begin
            errors++; $display("FAIL mid_first: got v=%b pc=%h expected v=1 pc=%h", bus.inst_valid, bus.inst_pc, RESET_PC);
        end
    endtask

    task automatic test_target_range();
`ifdef FETCH_FAULT_CHECK_EN
        do_reset();
        bus.inst_ready = 1'b1;
        step();
        step();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h42;
        step();
        bus.branch_target = 32'h80;
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus.fetch_fault !== 1'b1 || bus.inst_valid !== 1'b0 || bus.fetch_address !== 32'h42) begin
                errors++; $display("FAIL fault_misalign%0d: got f=%b v=%b addr=%h expected f=1 v=0 addr=42", c, bus.fetch_fault, bus.inst_valid, bus.fetch_address);
            end
            step();
            bus.branch_taken = 1'b0;
        end
        do_reset();
        checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b expected 0", bus.fetch_fault); end
        bus.inst_ready    = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h7FC;
        step();
        bus.branch_taken = 1'b0;
        step();
        checks++; if (bus.fetch_fault !== 1'b0 || bus.fetch_address !== 32'h800) begin
            errors++; $display("FAIL fault_last: got f=%b addr=%h expected f=0 addr=800", bus.fetch_fault, bus.fetch_address);
        end
        step();
        checks++; if (bus.fetch_fault !== 1'b1 || bus.inst_valid !== 1'b0 || bus.fetch_address !== 32'h800) begin
            errors++; $display("FAIL fault_seq: got f=%b v=%b addr=%h expected f=1 v=0 addr=800", bus.fetch_fault, bus.inst_valid, bus.fetch_address);
        end
`else
        logic [31:0] exp;
        do_reset();
        bus.inst_ready = 1'b1;
        step();
        step();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h42;
        step();
        bus.branch_taken = 1'b0;
        checks++; if (bus.fetch_address !== 32'h40 || bus.fetch_fault !== 1'b0) begin
            errors++; $display("FAIL align_addr: got addr=%h f=%b expected addr=40 f=0", bus.fetch_address, bus.fetch_fault);
        end
        step();
        step();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h40) begin
            errors++; $display("FAIL align_deliver: got v=%b pc=%h expected v=1 pc=40", bus.inst_valid, bus.inst_pc);
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h7F8;
        step();
        bus.branch_taken = 1'b0;
        step();
        step();
        checks++; if (bus.fetch_address !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", bus.fetch_address); end
        exp = 32'h7F8;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== exp || bus.inst_out !== mem[exp[10:2]]) begin
                errors++; $display("FAIL wrap_seq%0d: got v=%b pc=%h expected v=1 pc=%h", i, bus.inst_valid, bus.inst_pc, exp);
            end
            exp = (exp + 32'h4) % 32'(MEM_BYTES);
            step();
        end
`endif
    endtask

    // Randomized traffic: delivered PCs must follow the last redirect target in order
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        logic        rdy;
        logic        br;
        int          gap;
        do_reset();
        exp_pc = RESET_PC;
        gap    = 0;
        for (int c = 0; c < 3000; c++) begin
            if (bus.inst_valid) gap = 0; else gap++;
            checks++; if (gap > 2) begin errors++; $display("FAIL rand_stall c%0d: valid low for %0d cycles, at most 2 allowed", c, gap); end
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 15) == 0);
`ifdef FETCH_FAULT_CHECK_EN
            if (exp_pc > 32'h600) br = 1'b1;
            tgt = 32'($urandom_range(0, 255)) << 2;
`else
            tgt = 32'($urandom_range(0, MEM_BYTES - 1));
`endif
            if (bus.inst_valid && rdy) begin
                checks++; if (bus.inst_pc !== exp_pc || bus.inst_out !== mem[exp_pc[10:2]]) begin
                    errors++; $display("FAIL rand_pop c%0d: got pc=%h inst=%h expected pc=%h inst=%h", c, bus.inst_pc, bus.inst_out, exp_pc, mem[exp_pc[10:2]]);
                end
`ifdef FETCH_FAULT_CHECK_EN
                exp_pc = exp_pc + 32'h4;
`else
                exp_pc = (exp_pc + 32'h4) % 32'(MEM_BYTES);
`endif
            end
            if (br) begin
                exp_pc = tgt - (tgt % 32'h4);
                gap    = 0;
            end
            bus.inst_ready    = rdy;
            bus.branch_taken  = br;
            bus.branch_target = tgt;
            step();
        end
        bus.branch_taken = 1'b0;
        checks++; if (bus.fetch_fault !== 1'b0) begin errors++; $display("FAIL rand_fault: got %b expected 0", bus.fetch_fault); end
    endtask

    initial begin
        clk               = 1'b0;
        resetn            = 1'b0;
        checks            = 0;
        errors            = 0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.inst_ready    = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = $urandom;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_reset_midstream();
        test_target_range();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
